// File: rtl/data_memory_unit.sv
// Data memory stage: register-array storage with a registered read path
// (write-through forwarding) and a one-location-per-cycle hardware clear sweep.
module data_memory_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  clear_req,
  input  logic [ADDR_WIDTH-1:0] mem_access_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  clear_done
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   counter;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    sweep_last;
  logic                    start_clear;
  logic                    do_write;
  logic                    do_read;

  assign sweep_last = (counter == LAST_ADDR);

  // NOTE: every signal gets a default before the case so no path can leave one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    start_clear = 1'b0;
    do_write    = 1'b0;
    do_read     = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          next_state  = CLEAR;
          start_clear = 1'b1;
        end else begin
          do_write = mem_write;
          do_read  = mem_read;
        end
      end
      CLEAR: begin
        if (sweep_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      if (start_clear)          counter <= '0;
      else if (state == CLEAR)  counter <= counter + ADDR_WIDTH'(1);
      busy       <= (next_state == CLEAR);
      clear_done <= (state == CLEAR) && sweep_last;
      read_valid <= do_read;
      if (do_read) begin
        // Same-address write in the same cycle is forwarded to the read port.
        if (do_write && (mem_access_addr == mem_access_addr)) begin
          read_data <= write_data;
        end else begin
          read_data <= mem[mem_access_addr];
        end
      end
    end
  end

  // NOTE: the array is reset explicitly because unwritten locations must read
  // as zero; this keeps it in flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[counter] <= '0;
    end else if (do_write) begin
      mem[mem_access_addr] <= write_data;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed steps plus a randomized
// phase, all compared against a behavioural array/countdown model.
module tb_data_memory_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_write = 1'b0;
  logic       mem_read = 1'b0;
  logic       clear_req = 1'b0;
  logic [3:0] mem_access_addr = '0;
  logic [7:0] write_data = '0;
  logic [7:0] read_data;
  logic       read_valid;
  logic       busy;
  logic       clear_done;

  int checks = 0;
  int failures = 0;

  // Reference model: plain byte array, sweep expressed as "cycles left".
  logic [7:0] m_mem [16];
  logic [7:0] m_rd;
  logic       m_valid, m_busy, m_done;
  int         sweep_left;

  data_memory_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .clear_req       (clear_req),
    .mem_access_addr (mem_access_addr),
    .write_data      (write_data),
    .read_data       (read_data),
    .read_valid      (read_valid),
    .busy            (busy),
    .clear_done      (clear_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_rd = 8'h00; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    sweep_left = 0;
  endtask

  task automatic check_outputs(input string where);
    check({where, ":read_valid"}, {7'd0, read_valid}, {7'd0, m_valid});
    check({where, ":read_data"},  read_data,          m_rd);
    check({where, ":busy"},       {7'd0, busy},       {7'd0, m_busy});
    check({where, ":clear_done"}, {7'd0, clear_done}, {7'd0, m_done});
  endtask

  // One clock: drive on the falling edge, advance the model, sample 1ns after the rising edge.
  task automatic step(input logic w, input logic r, input logic c,
                      input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    mem_write = w; mem_read = r; clear_req = c; mem_access_addr = a; write_data = d;
    @(posedge clk);
    #1;
    m_done  = 1'b0;
    m_valid = 1'b0;
    if (sweep_left > 0) begin
      m_mem[16 - sweep_left] = 8'h00;
      sweep_left--;
      m_busy = (sweep_left > 0);
      m_done = (sweep_left == 0);
    end else if (c) begin
      sweep_left = 16;
      m_busy = 1'b1;
    end else begin
      if (w) m_mem[a] = d;
      if (r) begin
        m_rd    = m_mem[a];
        m_valid = 1'b1;
      end
    end
    check_outputs("step");
  endtask

  task automatic idle_inputs();
    mem_write = 1'b0; mem_read = 1'b0; clear_req = 1'b0;
  endtask

  // Async reset asserted mid-cycle, held across one rising edge, released on a falling edge.
  task automatic reset_mid_cycle(input string where);
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(where);
    @(posedge clk);
    #1;
    check_outputs(where);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read, then async reset while outputs are nonzero.
    step(1, 0, 0, 4'd3, 8'hA5);
    step(0, 1, 0, 4'd3, 8'h00);
    check("a5_read", read_data, 8'hA5);
    step(0, 0, 0, 4'd3, 8'h00);
    check("a5_hold", read_data, 8'hA5);
    step(0, 1, 0, 4'd3, 8'h00);
    reset_mid_cycle("reset_basic");

    // Write-through forwarding on a same-address write+read.
    step(1, 0, 0, 4'd7, 8'h11);
    step(1, 1, 0, 4'd7, 8'h3C);
    check("fwd_new", read_data, 8'h3C);
    step(0, 1, 0, 4'd7, 8'h00);
    check("fwd_after", read_data, 8'h3C);

    // Boundary addresses do not alias.
    step(1, 0, 0, 4'd15, 8'hFF);
    step(1, 0, 0, 4'd0,  8'h01);
    step(0, 1, 0, 4'd15, 8'h00);
    check("addr15", read_data, 8'hFF);
    step(0, 1, 0, 4'd0,  8'h00);
    check("addr0", read_data, 8'h01);

    // Fill, sweep with a write attempted mid-sweep, read everything back.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 4'(i), 8'(8'h80 + i));
    step(0, 0, 1, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) step(1, 0, 0, 4'd5, 8'h77);
      else        step(0, 0, 0, 4'd0, 8'h00);
    end
    check("sweep_done_pulse", {7'd0, clear_done}, 8'h01);
    step(0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 8'h00);
      check("swept_zero", read_data, 8'h00);
    end

    // clear_req beats a simultaneous write.
    step(1, 0, 0, 4'd2, 8'h5A);
    step(1, 0, 1, 4'd2, 8'h99);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 4'd0, 8'h00);
    step(0, 1, 0, 4'd2, 8'h00);
    check("prio_zero", read_data, 8'h00);

    // clear_req held high restarts a sweep right after clear_done.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 4'd0, 8'h00);

    // Reset at sweep cycle 6.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 4'(i), 8'hC3);
    step(0, 0, 1, 4'd0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 4'd0, 8'h00);
    reset_mid_cycle("reset_sweep");
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 8'h00);
      check("post_reset_zero", read_data, 8'h00);
    end

    // Randomized traffic with occasional sweeps.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 24) == 0), 4'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Data memory stage directly downstream of the data transfer unit. Consumes the registered mem_access_addr / write_data pair plus aligned read/write strobes, and stores bytes in a DEPTH-entry register array. Provides a registered read path with a one-cycle valid pulse. Also provides a hardware clear sweep that zeroes the whole array, one location per cycle, under a busy flag.

Parameters:
DATA_WIDTH, 8, width of each memory word and of the data buses
ADDR_WIDTH, 4, address width
DEPTH, 16, number of locations; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mem_write  input  1  write strobe; must be aligned with the mem_access_addr/write_data values from the DTU
mem_read  input  1  read strobe; aligned the same way as mem_write
clear_req  input  1  request to start a clear sweep; level-sampled
mem_access_addr  input  ADDR_WIDTH  location for the read/write
write_data  input  DATA_WIDTH  write data
read_data  output  DATA_WIDTH  registered read result; holds its value until the next read
read_valid  output  1  one-cycle pulse; read_data was updated at this edge
busy  output  1  high while a clear sweep is running
clear_done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (async, rst_n=0):
  - all array words = 0
  - read_data = 0, read_valid = 0, busy = 0, clear_done = 0
  - state = IDLE, sweep counter = 0
  - Takes effect immediately, including mid-sweep.
- States: IDLE, CLEAR.
- IDLE, at each posedge, with priority clear_req > accesses:
  - clear_req=1: go to CLEAR, counter <= 0, busy <= 1. Any mem_write/mem_read in that same cycle is dropped, so read_valid stays 0.
  - mem_write=1: mem[addr] <= write_data.
  - mem_read=1: read_data <= mem[addr], read_valid <= 1. Read latency is 1 cycle.
  - Write and read in the same cycle are both performed. If the addresses match, read_data returns the new write_data (write-through forwarding).
  - No read in the cycle: read_valid <= 0 and read_data holds.
- CLEAR, each posedge:
  - mem[counter] <= 0, counter <= counter+1.
  - When counter == DEPTH-1: state <= IDLE, busy <= 0, clear_done <= 1 for exactly one cycle.
  - Sweep timing: clear_req sampled at edge N; locations 0..15 are zeroed at edges N+1..N+16; busy is high from N to N+16; clear_done is high from N+16 to N+17.
  - mem_write, mem_read and clear_req are ignored throughout CLEAR; read_valid = 0.
- Counter is ADDR_WIDTH bits and wraps 15 -> 0 naturally. The exit decision uses counter == DEPTH-1, not overflow.
- clear_req held high is re-sampled in IDLE. The cycle after clear_done, a new sweep starts if clear_req is still 1.
- Addresses are always in range (the full 4-bit space is backed); there is no out-of-range case.
- Read data is never X after reset; unwritten locations read 0.

Test Plan:
- Reset and basic read/write: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release, write 8'hA5 to addr 3, then read addr 3 -> read_data=8'hA5 with read_valid high for exactly 1 cycle, one edge after the read strobe.
- Forwarding: same cycle mem_write=1, mem_read=1, addr 7, write_data 8'h3C, old mem[7]=8'h11 -> read_data=8'h3C. A following read of addr 7 -> 8'h3C.
- Boundary addresses: write 8'hFF to addr 15 and 8'h01 to addr 0, then read both -> 8'hFF and 8'h01; no aliasing.
- Clear sweep: fill all 16 locations with nonzero data, pulse clear_req for 1 cycle. Required response:
  - busy high for 16 cycles
  - clear_done pulses once at edge N+16
  - a write of 8'h77 to addr 5 issued mid-sweep is ignored
  - reads of all 16 addresses afterwards return 8'h00
- Priority: clear_req=1 together with mem_write=1 (addr 2, 8'h99) in IDLE -> the write is dropped, the sweep starts, and mem[2] reads 8'h00 afterwards.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 6 -> busy=0, clear_done never pulses, state IDLE. After release, an immediate read proceeds normally and the array is all zero.
